mmb_update_sched: RTL and testbench
===================================

Name: mmb_update_sched

Overview:
- Front-end scheduler for the memory match block.
- Arbitrates rule-insert requests from NREQ requesters into the ping-pong temp banks that the merge FSM sorts and merges into the big rule memory.
- Maintains the per-bank temp counts the merge FSM consumes.
- Gates search admission so a completed merge can swap big banks within a bounded time.

Parameters:
- RULE_W, 128, rule word width (matches CONCAT_WIDTH).
- NREQ, 2, number of insert requesters.
- TEMP_DEPTH, 16, entries per temp bank (power of 2).
- RULE_CAP, 512, big rule memory capacity.
- MAX_INFLIGHT, 4, maximum outstanding searches.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  insert request per requester.
- req_rule  in  NREQ*RULE_W  rule for requester i at [i*RULE_W +: RULE_W].
- req_ready  out  NREQ  one-hot grant; transfer when valid & ready.
- tempactive  in  1  fill-bank select from merge FSM.
- donemerge  in  1  merge finished, swap pending.
- doswap  in  1  swap pulse from merge FSM.
- rulecount  in  $clog2(RULE_CAP)+1  valid rules in active big bank.
- temp_we  out  1  temp bank write strobe.
- temp_bank  out  1  bank written.
- temp_waddr  out  $clog2(TEMP_DEPTH)  write index.
- temp_wdata  out  RULE_W  write data.
- tempcount0, tempcount1  out  $clog2(TEMP_DEPTH)+1 each  entries in bank 0 / bank 1.
- srch_valid  in  1  search request.
- srch_ready  out  1  search admitted.
- srch_done  in  1  one search completed.
- searchactive  out  1  any search outstanding.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset_n low at a clock edge): all of the following clear to 0 — tempcount0/1, RR pointer, inflight, err, temp_we, temp_bank, temp_waddr, temp_wdata, state. req_ready, srch_ready and searchactive are 0 while reset_n is low. Reset mid-write discards the write; temp contents are don't-care.
- Fill bank: F = tempactive sampled in the grant cycle. A write in the same cycle the FSM toggles tempactive lands in the old bank; its count updates at that edge.
- Capacity: ok = rulecount + tempcount0 + tempcount1 + 1 <= RULE_CAP, computed at full width with no wrap.
- State machine:
  - ST_OPEN: accept permitted.
  - ST_FULL: entered when tempcount[F] == TEMP_DEPTH. Exit to ST_OPEN when tempactive changes to a bank whose count is 0.
  - ST_CAP: entered when !ok. Re-evaluated every cycle; exit to ST_OPEN when ok.
  - ST_FULL takes priority over ST_CAP.
- Arbiter:
  - Round-robin over req_valid, starting at pointer p. Grant only in ST_OPEN with ok and tempcount[F] < TEMP_DEPTH.
  - req_ready combinationally depends on req_valid; requesters must not make valid depend on ready.
  - After an accept by requester g, p <= (g+1) mod NREQ. With no accept, p holds.
- Write path (1-cycle latency): accept at cycle t produces, at t+1, temp_we=1, temp_bank=F, temp_waddr=old tempcount[F], temp_wdata=granted rule. tempcount[F] increments at the t edge.
- Drain: on doswap, clear the count of bank ~tempactive (the merged bank). doswap and an accept in the same cycle on different banks are both applied.
- Overrun: if tempactive toggles to a bank with a nonzero count, or doswap arrives while donemerge=0, set err and keep counts unchanged.
- Search gate:
  - srch_ready = reset_n & !donemerge & (inflight < MAX_INFLIGHT).
  - inflight += accept, -= srch_done; simultaneous accept and srch_done leaves it unchanged.
  - srch_done with inflight==0 sets err and does not decrement.
  - searchactive = (inflight != 0), registered count.
  - While donemerge=1, no new search is admitted, so doswap occurs at most MAX_INFLIGHT completions later.

Test Plan:
- Reset → all outputs 0. Assert req_valid=2'b11, tempactive=0, rulecount=0 → grants alternate r0,r1,r0,…. temp_waddr runs 0,1,2,…; tempcount0 increments once per cycle.
- Fill bank 1 to 16 entries with tempactive=1 and no toggle → ST_FULL, req_ready=0. Toggle tempactive to 0 with tempcount0=0 → ST_OPEN, next write goes to bank 0, addr 0.
- rulecount=510, tempcount0=1 → exactly one more accept, then ST_CAP and req_ready=0. Set rulecount=500 → ST_OPEN resumes.
- Admit 4 searches → srch_ready=0. Raise donemerge, pulse srch_done ×4 → searchactive=0. Pulse doswap → merged bank's count clears, err stays 0.
- Same-cycle srch_valid accept and srch_done with inflight=2 → inflight stays 2.
- srch_done with inflight=0, or doswap without donemerge → err=1 and held until reset_n=0.

Source files
------------

// File: rtl/mmb_update_sched.sv
// Insert scheduler for the memory match block: arbitrates requesters into the
// ping-pong temp banks, tracks per-bank counts and gates search admission.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_OPEN | inserts may be accepted into the fill bank
// ST_FULL | fill bank holds TEMP_DEPTH rules, wait for a swap to an empty bank
// ST_CAP  | big memory plus temp banks at capacity, wait for room
module mmb_update_sched #(
  parameter int RULE_W       = 128,
  parameter int NREQ         = 2,
  parameter int TEMP_DEPTH   = 16,
  parameter int RULE_CAP     = 512,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ*RULE_W-1:0]          req_rule,
  output logic [NREQ-1:0]                 req_ready,
  input  logic                            tempactive,
  input  logic                            donemerge,
  input  logic                            doswap,
  input  logic [$clog2(RULE_CAP):0]       rulecount,
  output logic                            temp_we,
  output logic                            temp_bank,
  output logic [$clog2(TEMP_DEPTH)-1:0]   temp_waddr,
  output logic [RULE_W-1:0]               temp_wdata,
  output logic [$clog2(TEMP_DEPTH):0]     tempcount0,
  output logic [$clog2(TEMP_DEPTH):0]     tempcount1,
  input  logic                            srch_valid,
  output logic                            srch_ready,
  input  logic                            srch_done,
  output logic                            searchactive,
  output logic                            err
);

  localparam int AW = $clog2(TEMP_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = $clog2(RULE_CAP) + 3;

  typedef enum logic [1:0] {
    ST_OPEN = 2'd0,
    ST_FULL = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt0;
  logic [CW-1:0]       r_cnt1;
  logic [PW-1:0]       r_ptr;
  logic [IW-1:0]       r_inflight;
  logic                r_err;
  logic                r_ta_q;
  logic                r_we;
  logic                r_bank;
  logic [AW-1:0]       r_waddr;
  logic [RULE_W-1:0]   r_wdata;

  logic [CW-1:0]       w_cnt_f;
  logic [SW-1:0]       w_sum;
  logic                w_ok;
  logic                w_full;
  logic                w_room;
  logic                w_toggle;
  logic                w_open;
  logic                w_found;
  logic                w_accept;
  logic [PW-1:0]       w_idx;
  logic [PW-1:0]       w_gidx;
  logic [PW-1:0]       w_ptr_nxt;
  logic [RULE_W-1:0]   w_rule;
  logic                w_drain;
  logic                w_srch_acc;
  logic                w_done_ok;
  logic                w_overrun;

  assign w_cnt_f  = tempactive ? r_cnt1 : r_cnt0;
  // Summed wide enough that rulecount plus both banks can never wrap.
  assign w_sum    = SW'(rulecount) + SW'(r_cnt0) + SW'(r_cnt1) + SW'(1);
  assign w_ok     = (w_sum <= SW'(RULE_CAP));
  assign w_full   = (w_cnt_f == CW'(TEMP_DEPTH));
  assign w_room   = (w_cnt_f < CW'(TEMP_DEPTH));
  assign w_toggle = (tempactive != r_ta_q);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_OPEN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OPEN: begin
        if (w_full)     w_state_nxt = ST_FULL;
        else if (!w_ok) w_state_nxt = ST_CAP;
      end
      ST_FULL: begin
        if (w_toggle && (w_cnt_f == '0)) w_state_nxt = ST_OPEN;
      end
      ST_CAP: begin
        if (w_full)    w_state_nxt = ST_FULL;
        else if (w_ok) w_state_nxt = ST_OPEN;
      end
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  always_comb begin
    w_open = (r_state == ST_OPEN);
  end

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    w_accept  = reset_n & w_open & w_ok & w_room & w_found;
    req_ready = '0;
    if (w_accept) req_ready[w_gidx] = 1'b1;
  end

  assign w_ptr_nxt = PW'((int'(w_gidx) + 1) % NREQ);
  assign w_rule    = req_rule[int'(w_gidx)*RULE_W +: RULE_W];
  assign w_drain   = doswap & donemerge;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_bank  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_ptr   <= '0;
      r_ta_q  <= 1'b0;
    end else begin
      r_we   <= w_accept;
      r_ta_q <= tempactive;
      if (w_accept) begin
        r_bank  <= tempactive;
        r_waddr <= w_cnt_f[AW-1:0];
        r_wdata <= w_rule;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  // A drain always targets the bank not being filled, so it never collides
  // with an accept in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain && tempactive)         r_cnt0 <= '0;
      else if (w_accept && !tempactive)  r_cnt0 <= r_cnt0 + CW'(1);
      if (w_drain && !tempactive)        r_cnt1 <= '0;
      else if (w_accept && tempactive)   r_cnt1 <= r_cnt1 + CW'(1);
    end
  end

  assign srch_ready = reset_n & ~donemerge & (r_inflight < IW'(MAX_INFLIGHT));
  assign w_srch_acc = srch_valid & srch_ready;
  assign w_done_ok  = srch_done & (r_inflight != '0);
  assign w_overrun  = (w_toggle & (w_cnt_f != '0)) | (doswap & ~donemerge)
                    | (srch_done & (r_inflight == '0));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= r_inflight + IW'(w_srch_acc) - IW'(w_done_ok);
      if (w_overrun) r_err <= 1'b1;
    end
  end

  assign temp_we      = r_we;
  assign temp_bank    = r_bank;
  assign temp_waddr   = r_waddr;
  assign temp_wdata   = r_wdata;
  assign tempcount0   = r_cnt0;
  assign tempcount1   = r_cnt1;
  assign searchactive = reset_n & (r_inflight != '0);
  assign err          = r_err;

endmodule

// File: tb/tb_mmb_update_sched.sv
// Bench for mmb_update_sched: directed plan steps then constrained-random
// traffic, all checked every cycle against a bank/queue-level reference model.
module tb_mmb_update_sched;

  localparam int RULE_W       = 128;
  localparam int NREQ         = 2;
  localparam int TEMP_DEPTH   = 16;
  localparam int RULE_CAP     = 512;
  localparam int MAX_INFLIGHT = 4;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*RULE_W-1:0] req_rule;
  logic [NREQ-1:0]        req_ready;
  logic                   tempactive, donemerge, doswap;
  logic [9:0]             rulecount;
  logic                   temp_we, temp_bank;
  logic [3:0]             temp_waddr;
  logic [RULE_W-1:0]      temp_wdata;
  logic [4:0]             tempcount0, tempcount1;
  logic                   srch_valid, srch_ready, srch_done, searchactive, err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mmb_update_sched dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_rule(req_rule), .req_ready(req_ready),
    .tempactive(tempactive), .donemerge(donemerge), .doswap(doswap),
    .rulecount(rulecount),
    .temp_we(temp_we), .temp_bank(temp_bank), .temp_waddr(temp_waddr),
    .temp_wdata(temp_wdata), .tempcount0(tempcount0), .tempcount1(tempcount1),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_done(srch_done),
    .searchactive(searchactive), .err(err)
  );

  // Reference model: bank counts, pointer, outstanding searches, mode
  // (0 open, 1 fill bank full, 2 capacity stall), last write.
  int          m_cnt[2];
  int          m_ptr, m_infl, m_mode, m_waddr;
  bit          m_err, m_we, m_bank, m_ta_prev;
  logic [127:0] m_wdata;
  int          e_g;
  bit          e_acc, e_sready;
  logic [1:0]  e_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_ptr = 0; m_infl = 0; m_mode = 0; m_waddr = 0;
    m_err = 0; m_we = 0; m_bank = 0; m_ta_prev = 0; m_wdata = '0;
  endtask

  function automatic bit cap_ok();
    return (int'(rulecount) + m_cnt[0] + m_cnt[1] + 1) <= RULE_CAP;
  endfunction

  task automatic comb_model();
    int f;
    f   = int'(tempactive);
    e_g = -1;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (m_ptr + i) % NREQ;
      if (e_g < 0 && (((req_valid >> idx) & 2'b01) != 2'b00)) e_g = idx;
    end
    e_acc    = reset_n && (m_mode == 0) && cap_ok() && (m_cnt[f] < TEMP_DEPTH) && (e_g >= 0);
    e_ready  = e_acc ? 2'(1 << e_g) : 2'b00;
    e_sready = reset_n && !donemerge && (m_infl < MAX_INFLIGHT);
  endtask

  task automatic model_step();
    int f, nm;
    bit ok, tog, sacc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    f   = int'(tempactive);
    ok  = cap_ok();
    tog = (tempactive != m_ta_prev);
    nm  = m_mode;
    if (m_mode == 1) begin
      if (tog && m_cnt[f] == 0) nm = 0;
    end else if (m_cnt[f] == TEMP_DEPTH) nm = 1;
    else nm = ok ? 0 : 2;
    if (tog && m_cnt[f] != 0)      m_err = 1;
    if (doswap && !donemerge)      m_err = 1;
    if (srch_done && m_infl == 0)  m_err = 1;
    m_we = e_acc;
    if (e_acc) begin
      m_bank  = tempactive;
      m_waddr = m_cnt[f];
      m_wdata = req_rule[e_g*RULE_W +: RULE_W];
      m_cnt[f]++;
      m_ptr = (e_g + 1) % NREQ;
    end
    if (doswap && donemerge) m_cnt[1-f] = 0;
    sacc = srch_valid && e_sready;
    if (srch_done && m_infl == 0) m_infl += int'(sacc);
    else m_infl += int'(sacc) - int'(srch_done);
    m_ta_prev = tempactive;
    m_mode    = nm;
  endtask

  task automatic cycle();
    @(negedge clock);
    comb_model();
    chk("req_ready",    req_ready,    e_ready);
    chk("srch_ready",   srch_ready,   e_sready);
    chk("temp_we",      temp_we,      m_we);
    chk("temp_bank",    temp_bank,    m_bank);
    chk("temp_waddr",   temp_waddr,   m_waddr);
    chk("temp_wdata",   temp_wdata,   m_wdata);
    chk("tempcount0",   tempcount0,   m_cnt[0]);
    chk("tempcount1",   tempcount1,   m_cnt[1]);
    chk("searchactive", searchactive, (m_infl != 0) && reset_n);
    chk("err",          err,          m_err);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      req_rule = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
      cycle();
    end
  endtask

  initial begin
    int phase;
    reset_n = 0; req_valid = 2'b11; req_rule = '0; tempactive = 0;
    donemerge = 0; doswap = 0; rulecount = '0; srch_valid = 0; srch_done = 0;
    model_reset();
    run(2);
    chk("rst_tempcount0", tempcount0, 5'd0);
    chk("rst_temp_we",    temp_we,    1'b0);

    // Alternating grants into bank 0
    reset_n = 1;
    run(6);
    chk("fill0_count", tempcount0, 5'd6);
    chk("fill0_waddr", temp_waddr, 4'd5);

    // Fill bank 1 to full, drain bank 0, swap back
    tempactive = 1;
    run(20);
    chk("full_count1", tempcount1, 5'd16);
    donemerge = 1; doswap = 1;
    run(1);
    chk("drain0", tempcount0, 5'd0);
    donemerge = 0; doswap = 0; tempactive = 0;
    run(2);
    chk("reopen_bank", temp_bank,  1'b0);
    chk("reopen_addr", temp_waddr, 4'd0);
    chk("reopen_we",   temp_we,    1'b1);

    // Capacity stall at rulecount 510, resume at 500
    req_valid = 2'b00; donemerge = 1; doswap = 1;
    run(1);
    chk("drain1", tempcount1, 5'd0);
    donemerge = 0; doswap = 0; rulecount = 10'd510; req_valid = 2'b11;
    run(4);
    chk("cap_count", tempcount0, 5'd2);
    rulecount = 10'd500;
    run(2);
    chk("cap_resume", tempcount0, 5'd3);
    req_valid = 2'b00; rulecount = '0;

    // Search gate: four outstanding, merge drains them, swap clears bank 0
    tempactive = 1; srch_valid = 1;
    run(6);
    chk("srch_busy", searchactive, 1'b1);
    donemerge = 1; srch_done = 1;
    run(4);
    srch_done = 0;
    chk("srch_idle", searchactive, 1'b0);
    doswap = 1;
    run(1);
    doswap = 0; donemerge = 0; srch_valid = 0;
    chk("swap_clear", tempcount0, 5'd0);
    chk("swap_noerr", err, 1'b0);

    // Simultaneous admit and completion keeps two outstanding
    srch_valid = 1;
    run(2);
    srch_done = 1;
    run(1);
    srch_valid = 0; srch_done = 1;
    run(2);
    srch_done = 0;
    run(1);
    chk("infl_two_drained", searchactive, 1'b0);
    chk("infl_no_err",      err,          1'b0);

    // Protocol errors are sticky until reset
    srch_done = 1;
    run(1);
    srch_done = 0;
    run(2);
    chk("err_done_underflow", err, 1'b1);
    reset_n = 0;
    run(1);
    chk("err_cleared", err, 1'b0);
    reset_n = 1; doswap = 1;
    run(1);
    doswap = 0;
    run(1);
    chk("err_swap_no_merge", err, 1'b1);
    reset_n = 0;
    run(1);
    reset_n = 1;

    // Constrained random traffic with well-formed swap handshakes
    phase = 0;
    for (int c = 0; c < 600; c++) begin
      req_valid  = 2'($urandom_range(0, 3));
      srch_valid = 1'($urandom_range(0, 1));
      srch_done  = (m_infl > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rulecount  = ($urandom_range(0, 3) == 0) ? 10'(495 + $urandom_range(0, 17))
                                               : 10'($urandom_range(0, 400));
      if (phase == 1) begin
        donemerge = 0; doswap = 0; tempactive = ~tempactive; phase = 0;
      end else if ($urandom_range(0, 15) == 0 || m_cnt[int'(tempactive)] == TEMP_DEPTH) begin
        donemerge = 1; doswap = 1; phase = 1;
      end else begin
        donemerge = 0; doswap = 0;
      end
      run(1);
    end
    chk("random_no_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
